controle_tentativa: RTL

CONTROLE_TENTATIVA -- requirements
Module: controle_tentativa

---
 rtl/controle_tentativa_if.sv | 32 +++
 rtl/controle_tentativa.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/controle_tentativa_if.sv
// Guess-control bus: secret/guess inputs, comparator verdict, and round status.
// Latency: none (wiring only); the attached controller registers every output.
// Backpressure: none; confirma is a level whose rising edge submits one guess.
interface controle_tentativa_if;
  logic [3:0] senha;
  logic       carrega_senha;
  logic [3:0] tentativa;
  logic       confirma;
  logic       igual;
  logic       ate3;
  logic       errada;
  logic [3:0] diff;
  logic       sinal;
  logic       diff_valido;
  logic       vitoria;
  logic       derrota;
  logic       perto;
  logic [2:0] restantes;
  logic       ocupado;

  // Environment side: loads the secret, submits guesses, answers as comparator.
  modport master (
    output senha, carrega_senha, tentativa, confirma, igual, ate3, errada,
    input  diff, sinal, diff_valido, vitoria, derrota, perto, restantes, ocupado
  );

  // Controller side.
  modport slave (
    input  senha, carrega_senha, tentativa, confirma, igual, ate3, errada,
    output diff, sinal, diff_valido, vitoria, derrota, perto, restantes, ocupado
  );
endinterface

// File: rtl/controle_tentativa.sv
// Guessing-round controller: sends tentativa-senha to a comparator and scores its verdict.
// Latency: diff valid 1 edge after a confirma rising edge, verdict flags 2 edges after it.
// Backpressure: edges outside AGUARDA are dropped; DICA_PERTO_EN enables the "close" hint.
module controle_tentativa #(
  parameter int MAX_TENTATIVAS = 5
) (
  input logic             clk,
  input logic             reset,
  controle_tentativa_if.slave bus
);

`ifdef DICA_PERTO_EN
  localparam bit DICA_PERTO = 1'b1;
`else
  localparam bit DICA_PERTO = 1'b0;
`endif

  localparam logic [2:0] TENTATIVAS_INI = 3'(MAX_TENTATIVAS);

  typedef enum logic [2:0] {
    OCIOSO,
    AGUARDA,
    CALCULA,
    VITORIA,
    DERROTA
  } estado_t;

  typedef enum logic [1:0] {
    V_IGUAL,
    V_PERTO,
    V_ERRADA
  } veredito_t;

  estado_t    estado;
  veredito_t  veredito;
  logic [3:0] senha_reg;
  logic       confirma_ant;
  logic       armado;
  logic       borda;
  logic [3:0] diff_r;
  logic       sinal_r;
  logic       diff_valido_r;
  logic       vitoria_r;
  logic       derrota_r;
  logic       perto_r;
  logic [2:0] restantes_r;
  logic       ocupado_r;

  // Rising edge of confirma; suppressed on the first clock after reset release
  // so a level already high at that point is not taken as a submission.
  always_comb begin
    borda = bus.confirma & ~confirma_ant & armado;
  end

  // Verdict priority igual > ate3 > errada; all-zero falls through to errada.
  always_comb begin
    veredito = V_ERRADA;
    casez ({bus.igual, bus.ate3, bus.errada})
      3'b1??:  veredito = V_IGUAL;
      3'b01?:  veredito = V_PERTO;
      default: veredito = V_ERRADA;
    endcase
  end

  // Round FSM with all outputs registered; a new secret load overrides everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado        <= OCIOSO;
      senha_reg     <= '0;
      confirma_ant  <= 1'b0;
      armado        <= 1'b0;
      diff_r        <= '0;
      sinal_r       <= 1'b0;
      diff_valido_r <= 1'b0;
      vitoria_r     <= 1'b0;
      derrota_r     <= 1'b0;
      perto_r       <= 1'b0;
      restantes_r   <= '0;
      ocupado_r     <= 1'b0;
    end else begin
      confirma_ant <= bus.confirma;
      armado       <= 1'b1;
      if (bus.carrega_senha) begin
        // Any confirma edge in this same cycle is discarded.
        senha_reg     <= bus.senha;
        restantes_r   <= TENTATIVAS_INI;
        vitoria_r     <= 1'b0;
        derrota_r     <= 1'b0;
        perto_r       <= 1'b0;
        diff_valido_r <= 1'b0;
        ocupado_r     <= 1'b0;
        estado        <= AGUARDA;
      end else begin
        unique case (estado)
          AGUARDA: begin
            if (borda) begin
              // 5-bit two's complement: sinal is the sign bit, no saturation.
              {sinal_r, diff_r} <= {1'b0, bus.tentativa} - {1'b0, senha_reg};
              diff_valido_r     <= 1'b1;
              ocupado_r         <= 1'b1;
              estado            <= CALCULA;
            end
          end
          CALCULA: begin
            diff_valido_r <= 1'b0;
            ocupado_r     <= 1'b0;
            if (veredito == V_IGUAL) begin
              vitoria_r <= 1'b1;
              perto_r   <= 1'b0;
              estado    <= VITORIA;
            end else begin
              // Without the hint, ate3 scores exactly like errada.
              perto_r <= DICA_PERTO && (veredito == V_PERTO);
              if (restantes_r != 3'd0) begin
                restantes_r <= restantes_r - 3'd1;
              end
              if (restantes_r <= 3'd1) begin
                derrota_r <= 1'b1;
                estado    <= DERROTA;
              end else begin
                estado <= AGUARDA;
              end
            end
          end
          default: begin
            // OCIOSO, VITORIA and DERROTA hold until a secret load or reset.
            estado <= estado;
          end
        endcase
      end
    end
  end

  assign bus.diff        = diff_r;
  assign bus.sinal       = sinal_r;
  assign bus.diff_valido = diff_valido_r;
  assign bus.vitoria     = vitoria_r;
  assign bus.derrota     = derrota_r;
  assign bus.perto       = perto_r;
  assign bus.restantes   = restantes_r;
  assign bus.ocupado     = ocupado_r;

endmodule
